serial_addsub_cmp: RTL and testbench

- Parametrised, digit-serial add/subtract unit with a threshold-compare flag.
- Replaces the fixed 4-bit ripple subtractor with "result < 5" flag.
- Processes DIGIT bits per cycle through a small ripple slice, so arbitrary WIDTH costs one slice plus shift registers.
- Sits between the operand registers and the datapath status logic; controlled by a start/busy/done handshake.

---
 rtl/addsub_pkg.sv | 22 ++
 rtl/digit_adder.sv | 28 ++
 rtl/serial_addsub_cmp.sv | 133 +++++++++++++
 tb/tb_serial_addsub_cmp.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the digit-serial add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // WIDTH must be at least 2 and split into a whole number of digits.
  function automatic bit width_ok(int unsigned w, int unsigned d);
    return (d != 0) && (w >= 2) && ((w % d) == 0);
  endfunction

  function automatic bit thresh_ok(int unsigned w, int unsigned t);
    return (w >= 32) || (t < (32'd1 << w));
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-wide combinational ripple-carry slice; also exposes the carry into its MSB.
module digit_adder #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(DIGIT); i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub_cmp.sv
// Digit-serial add/subtract with carry, overflow and "result below THRESH" flags.
module serial_addsub_cmp
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGIT  = 2,
  parameter int unsigned THRESH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             below,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!width_ok(WIDTH, DIGIT) || !thresh_ok(WIDTH, THRESH)) begin : g_param_err
    $error("serial_addsub_cmp: illegal WIDTH/DIGIT/THRESH combination");
  end

  state_t           state_q, state_d;
  logic             accept;
  logic             busy_d, done_d;
  logic [WIDTH-1:0] a_sh, b_sh, acc, y_full;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [DIGIT-1:0] slice_s;
  logic             slice_cout, slice_cmsb;
  logic             below_n;

  // Next-state and handshake decode.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        accept  = 1'b1;
      end
      RUN:  if (cnt_q == LAST) state_d = DONE;
      DONE: begin
        if (start) begin
          state_d = RUN;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .a     (a_sh[DIGIT-1:0]),
    .b     (b_sh[DIGIT-1:0]),
    .cin   (carry_q),
    .s     (slice_s),
    .cout  (slice_cout),
    .c_msb (slice_cmsb)
  );

  // Working result with the current digit merged in; published only on the last digit.
  always_comb begin
    y_full                      = acc;
    y_full[cnt_q*DIGIT +: DIGIT] = slice_s;
  end

  if (THRESH == 0) begin : g_no_thresh
    assign below_n = 1'b0;
  end else begin : g_thresh
    assign below_n = (y_full < WIDTH'(THRESH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      y       <= '0;
      cout    <= 1'b0;
      below   <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      // Subtract is a + ~b + 1: invert b here and seed the carry with mode.
      a_sh    <= a;
      b_sh    <= (mode == MODE_SUB) ? ~b : b;
      carry_q <= mode;
      cnt_q   <= '0;
      acc     <= '0;
    end else if (state_q == RUN) begin
      a_sh    <= a_sh >> DIGIT;
      b_sh    <= b_sh >> DIGIT;
      carry_q <= slice_cout;
      cnt_q   <= cnt_q + 1'b1;
      acc     <= y_full;
      if (cnt_q == LAST) begin
        y     <= y_full;
        cout  <= slice_cout;
        ovf   <= slice_cout ^ slice_cmsb;
        below <= below_n;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_cmp.sv
// Bench for serial_addsub_cmp: four parameterisations against a cycle-level arithmetic model.
module tb_serial_addsub_cmp;

  localparam int unsigned NI = 4;
  localparam int unsigned WS [NI] = '{8, 16, 16, 16};
  localparam int unsigned DS [NI] = '{2, 1, 4, 16};
  localparam int unsigned TS [NI] = '{5, 300, 0, 5};

  logic        clk, rst_n, start, mode;
  logic [15:0] a, b;

  logic        busy_v [NI];
  logic        done_v [NI];
  logic        cout_v [NI];
  logic        below_v[NI];
  logic        ovf_v  [NI];
  logic [15:0] y_v    [NI];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  for (genvar g = 0; g < int'(NI); g++) begin : g_dut
    localparam int unsigned W = WS[g];
    logic [W-1:0] y_l;
    serial_addsub_cmp #(.WIDTH(W), .DIGIT(DS[g]), .THRESH(TS[g])) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .mode  (mode),
      .a     (a[W-1:0]),
      .b     (b[W-1:0]),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .y     (y_l),
      .cout  (cout_v[g]),
      .below (below_v[g]),
      .ovf   (ovf_v[g])
    );
    assign y_v[g] = 16'(y_l);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {ovf, below, cout, y[15:0]}.
  function automatic logic [18:0] ref_op(int unsigned w, int unsigned th, bit md,
                                         logic [15:0] ai, logic [15:0] bi);
    longint m, half, av, bv, r, sa, sb, sr;
    bit c, bl, ov;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    av   = longint'(ai) & m;
    bv   = longint'(bi) & m;
    if (md) begin
      r = (av - bv) & m;
      c = (av >= bv);
    end else begin
      r = av + bv;
      c = (r > m);
      r = r & m;
    end
    sa = (av >= half) ? av - (m + 1) : av;
    sb = (bv >= half) ? bv - (m + 1) : bv;
    sr = md ? sa - sb : sa + sb;
    ov = (sr < -half) || (sr >= half);
    bl = (r < longint'(th));
    return {ov, bl, c, 16'(r)};
  endfunction

  // Cycle-level model: an accepted op shows done exactly N edges after the start edge.
  bit          m_busy [NI];
  bit          m_done [NI];
  int          m_left [NI];
  logic [18:0] m_pend [NI];
  logic [18:0] m_res  [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < int'(NI); g++) begin
        m_busy[g] = 0; m_done[g] = 0; m_left[g] = 0; m_pend[g] = '0; m_res[g] = '0;
      end
    end else begin
      for (int g = 0; g < int'(NI); g++) begin
        if (m_busy[g]) begin
          m_left[g]--;
          if (m_left[g] == 0) begin
            m_busy[g] = 0;
            m_done[g] = 1;
            m_res[g]  = m_pend[g];
          end
        end else begin
          m_done[g] = 0;
          if (start === 1'b1) begin
            m_pend[g] = ref_op(WS[g], TS[g], mode, a, b);
            m_busy[g] = 1;
            m_left[g] = int'(WS[g] / DS[g]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < int'(NI); g++) begin
        check($sformatf("busy[%0d]", g),  32'(busy_v[g]),  32'(m_busy[g]));
        check($sformatf("done[%0d]", g),  32'(done_v[g]),  32'(m_done[g]));
        check($sformatf("y[%0d]", g),     32'(y_v[g]),     32'(m_res[g][15:0]));
        check($sformatf("cout[%0d]", g),  32'(cout_v[g]),  32'(m_res[g][16]));
        check($sformatf("below[%0d]", g), 32'(below_v[g]), 32'(m_res[g][17]));
        check($sformatf("ovf[%0d]", g),   32'(ovf_v[g]),   32'(m_res[g][18]));
      end
    end
  end

  task automatic launch(bit md, logic [15:0] av, logic [15:0] bv);
    @(negedge clk);
    start = 1'b1; mode = md; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (done_v[0] !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic chk_res(string nm, logic [7:0] ey, bit ec, bit eb, bit eo);
    check({nm, ".y"},     32'(y_v[0]),     32'(ey));
    check({nm, ".cout"},  32'(cout_v[0]),  32'(ec));
    check({nm, ".below"}, 32'(below_v[0]), 32'(eb));
    check({nm, ".ovf"},   32'(ovf_v[0]),   32'(eo));
  endtask

  int lat;
  int sel;

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check("reset.busy", 32'(busy_v[0]), 32'd0);
    check("reset.done", 32'(done_v[0]), 32'd0);
    chk_res("reset", 8'h00, 0, 0, 0);
    rst_n = 1'b1;

    launch(1, 16'd9, 16'd6);
    wait_done(0, lat);
    check("sub9_6.latency", 32'(lat), 32'd4);
    chk_res("sub9_6", 8'h03, 1, 1, 0);

    launch(1, 16'd3, 16'd5);
    wait_done(0, lat);
    chk_res("sub3_5", 8'hFE, 0, 0, 0);

    launch(1, 16'h80, 16'h01);
    wait_done(0, lat);
    chk_res("sub80_01", 8'h7F, 1, 0, 1);

    launch(0, 16'hFF, 16'h01);
    wait_done(0, lat);
    chk_res("addFF_01", 8'h00, 1, 1, 0);

    launch(0, 16'h7F, 16'h01);
    wait_done(0, lat);
    chk_res("add7F_01", 8'h80, 0, 0, 1);

    launch(1, 16'h2A, 16'h2A);
    wait_done(0, lat);
    chk_res("sub_eq", 8'h00, 1, 1, 0);

    // Starts pulsed while running must be dropped.
    launch(1, 16'd9, 16'd6);
    start = 1'b1; mode = 1'b0; a = 16'd1; b = 16'd1;
    @(negedge clk);
    a = 16'd77; b = 16'd33;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, lat);
    check("ignored.latency", 32'(lat), 32'd4);
    chk_res("ignored", 8'h03, 1, 1, 0);

    // Back-to-back: start held through the DONE cycle.
    start = 1'b1; mode = 1'b1; a = 16'd20; b = 16'd4;
    @(negedge clk);
    start = 1'b0;
    check("b2b.busy", 32'(busy_v[0]), 32'd1);
    wait_done(0, lat);
    check("b2b.latency", 32'(lat), 32'd4);
    chk_res("b2b", 8'h10, 1, 0, 0);

    // Asynchronous reset in the middle of a run.
    launch(0, 16'h30, 16'h22);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst.busy", 32'(busy_v[0]), 32'd0);
    check("midrst.done", 32'(done_v[0]), 32'd0);
    chk_res("midrst", 8'h00, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst.no_done", 32'(done_v[0]), 32'd0);

    launch(0, 16'd2, 16'd2);
    wait_done(0, lat);
    check("post_rst.latency", 32'(lat), 32'd4);
    chk_res("post_rst", 8'h04, 0, 1, 0);

    // Random traffic; the per-cycle compare covers every instance.
    repeat (4000) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      mode  = 1'($urandom);
      a     = 16'($urandom);
      b     = 16'($urandom);
      sel   = int'($urandom_range(0, 9));
      if (sel == 0) b = a;
      if (sel == 1) a = 16'hFFFF;
      if (sel == 2) b = 16'h0001;
      if (sel == 3) begin a = 16'($urandom_range(0, 8)); b = 16'($urandom_range(0, 8)); end
      if (sel == 4) a = 16'h8000;
    end
    // Continuous start exercises back-to-back issue on every instance.
    repeat (400) begin
      @(negedge clk);
      start = 1'b1;
      mode  = 1'($urandom);
      a     = 16'($urandom);
      b     = 16'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
